// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sort memory responder slice: default widths,
// response codes and the read/write FSM state encodings.
// ----------------------------------------------------------------------------
package sort_pkg;

   localparam int ADDR_WDTH_DFLT = 4;
   localparam int DATA_WDTH_DFLT = 32;
   localparam int RESP_WDTH_DFLT = 1;

   localparam int RESP_OKAY = 0;
   localparam int RESP_ERR  = 1;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_HAVE_A = 2'd1,
      W_HAVE_D = 2'd2,
      W_RESP   = 2'd3
   } w_state_e;

endpackage : sort_pkg

// File: rtl/sort_mem_responder_if.sv
// ----------------------------------------------------------------------------
// sort_mem_responder_if
// Valid/ready memory bus: read address (ar), read data (r), write address
// (aw), write data (w) and write response (b) channels.
//   master : drives request channels, consumes r and b
//   slave  : the responder side
// ----------------------------------------------------------------------------
interface sort_mem_responder_if #(
   parameter int ADDR_WDTH = sort_pkg::ADDR_WDTH_DFLT,
   parameter int DATA_WDTH = sort_pkg::DATA_WDTH_DFLT,
   parameter int RESP_WDTH = sort_pkg::RESP_WDTH_DFLT
);

   logic                 ar_valid;
   logic                 ar_ready;
   logic [ADDR_WDTH-1:0] ar_addr;

   logic                 r_valid;
   logic                 r_ready;
   logic [DATA_WDTH-1:0] r_data;
   logic [RESP_WDTH-1:0] r_resp;

   logic                 aw_valid;
   logic                 aw_ready;
   logic [ADDR_WDTH-1:0] aw_addr;

   logic                 w_valid;
   logic                 w_ready;
   logic [DATA_WDTH-1:0] w_data;

   logic                 b_valid;
   logic                 b_ready;
   logic [RESP_WDTH-1:0] b_resp;

   modport master (
      output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, b_ready,
      output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

endinterface : sort_mem_responder_if

// File: rtl/sort_mem_array.sv
// ----------------------------------------------------------------------------
// sort_mem_array
// 2^ADDR_WDTH signed words, one registered read port, one write port,
// asynchronous clear of every word and of the read register.
//   clk, rst_n         : clock, async active-low clear
//   rd_en/rd_addr      : capture mem[rd_addr] into rd_data on the edge
//   rd_data            : registered read word, holds until next rd_en
//   wr_en/addr/data    : write port
// ----------------------------------------------------------------------------
module sort_mem_array #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        rd_en,
   input  logic        [ADDR_WDTH-1:0] rd_addr,
   output logic signed [DATA_WDTH-1:0] rd_data,
   input  logic                        wr_en,
   input  logic        [ADDR_WDTH-1:0] wr_addr,
   input  logic signed [DATA_WDTH-1:0] wr_data
);

   localparam int DEPTH = 1 << ADDR_WDTH;

   logic signed [DATA_WDTH-1:0] mem [DEPTH];

   // NOTE: the memory sits inside the reset branch on purpose -- every word
   // must read 0 after reset, so this storage is flops, not a RAM macro.
   // NOTE: non-blocking updates make a read on the same edge as a write to
   // that word see the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= wr_data;
         if (rd_en) rd_data <= mem[rd_addr];
      end
   end

endmodule : sort_mem_array

// File: rtl/sort_mem_responder.sv
// ----------------------------------------------------------------------------
// sort_mem_responder
// Memory-backed responder with independent read and write FSMs.
//   clk, rst_n : clock (rising edge), async active-low reset
//   arr_size   : number of valid words (used only with range checking)
//   bus        : sort_mem_responder_if.slave (ar/r/aw/w/b channels)
// Build option: define SORT_MEM_RANGE_CHECK_EN to answer addresses
// >= arr_size with an error response (reads return 0, writes are dropped).
// ----------------------------------------------------------------------------
module sort_mem_responder
   import sort_pkg::*;
#(
   parameter int ADDR_WDTH = ADDR_WDTH_DFLT,
   parameter int DATA_WDTH = DATA_WDTH_DFLT,
   parameter int RESP_WDTH = RESP_WDTH_DFLT
) (
   input logic                 clk,
   input logic                 rst_n,
   input logic [ADDR_WDTH:0]   arr_size,
   sort_mem_responder_if.slave bus
);

   r_state_e r_state_q, r_state_d;
   w_state_e w_state_q, w_state_d;

   logic                 ar_fire;
   logic                 rd_oob, wr_oob;
   logic                 r_err_q, b_err_q;
   logic [DATA_WDTH-1:0] rd_data;

   logic                 aw_rdy, w_rdy, b_vld;
   logic                 wr_done;
   logic [ADDR_WDTH-1:0] wr_addr, aw_addr_q;
   logic [DATA_WDTH-1:0] wr_data, w_data_q;

`ifdef SORT_MEM_RANGE_CHECK_EN
   assign rd_oob = ({1'b0, bus.ar_addr} >= arr_size);
   assign wr_oob = ({1'b0, wr_addr}     >= arr_size);
`else
   logic unused_arr_size;
   assign unused_arr_size = ^arr_size;
   assign rd_oob = 1'b0;
   assign wr_oob = 1'b0;
`endif

   // ---------------- read channel ----------------
   assign ar_fire = (r_state_q == R_IDLE) && bus.ar_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         r_err_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         if (ar_fire) r_err_q <= rd_oob;
      end
   end

   // Leaving R_DATA always goes to R_IDLE, so a read cannot be taken on the
   // same edge as the r transfer.
   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         R_IDLE:  if (bus.ar_valid) r_state_d = R_DATA;
         R_DATA:  if (bus.r_ready)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   assign bus.ar_ready = (r_state_q == R_IDLE);
   assign bus.r_valid  = (r_state_q == R_DATA);
   assign bus.r_data   = r_err_q ? '0 : rd_data;
   assign bus.r_resp   = r_err_q ? RESP_WDTH'(RESP_ERR) : RESP_WDTH'(RESP_OKAY);

   // ---------------- write channel ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         b_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         if (aw_rdy && bus.aw_valid) aw_addr_q <= bus.aw_addr;
         if (w_rdy  && bus.w_valid)  w_data_q  <= bus.w_data;
         if (wr_done)                b_err_q   <= wr_oob;
      end
   end

   // The pair completes on whichever edge delivers the second half; the
   // write takes the held half from its register and the other from the bus.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unset,
      // which would otherwise infer a latch.
      w_state_d = w_state_q;
      aw_rdy    = 1'b0;
      w_rdy     = 1'b0;
      b_vld     = 1'b0;
      wr_done   = 1'b0;
      wr_addr   = bus.aw_addr;
      wr_data   = bus.w_data;
      unique case (w_state_q)
         W_IDLE: begin
            aw_rdy = 1'b1;
            w_rdy  = 1'b1;
            if (bus.aw_valid && bus.w_valid) begin
               wr_done   = 1'b1;
               w_state_d = W_RESP;
            end else if (bus.aw_valid) begin
               w_state_d = W_HAVE_A;
            end else if (bus.w_valid) begin
               w_state_d = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            w_rdy   = 1'b1;
            wr_addr = aw_addr_q;
            if (bus.w_valid) begin
               wr_done   = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_HAVE_D: begin
            aw_rdy  = 1'b1;
            wr_data = w_data_q;
            if (bus.aw_valid) begin
               wr_done   = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_vld = 1'b1;
            if (bus.b_ready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign bus.aw_ready = aw_rdy;
   assign bus.w_ready  = w_rdy;
   assign bus.b_valid  = b_vld;
   assign bus.b_resp   = b_err_q ? RESP_WDTH'(RESP_ERR) : RESP_WDTH'(RESP_OKAY);

   // ---------------- storage ----------------
   sort_mem_array #(
      .ADDR_WDTH (ADDR_WDTH),
      .DATA_WDTH (DATA_WDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (ar_fire),
      .rd_addr (bus.ar_addr),
      .rd_data (rd_data),
      .wr_en   (wr_done && !wr_oob),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

endmodule : sort_mem_responder

// File: tb/tb_sort_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_sort_mem_responder
// Directed bench for sort_mem_responder. Inputs change on the falling edge,
// outputs are sampled on the falling edge, transfers happen on the rising edge.
// ----------------------------------------------------------------------------
module tb_sort_mem_responder;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int RW = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW:0]   arr_size;
   int            tests_run = 0;
   int            tests_failed = 0;

   sort_mem_responder_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) bus ();

   sort_mem_responder #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .arr_size (arr_size),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'd1);
      check({tag, "_aw_ready"}, 64'(bus.aw_ready), 64'd1);
      check({tag, "_w_ready"},  64'(bus.w_ready),  64'd1);
      check({tag, "_r_valid"},  64'(bus.r_valid),  64'd0);
      check({tag, "_b_valid"},  64'(bus.b_valid),  64'd0);
      check({tag, "_r_data"},   64'(bus.r_data),   64'd0);
      check({tag, "_r_resp"},   64'(bus.r_resp),   64'd0);
      check({tag, "_b_resp"},   64'(bus.b_resp),   64'd0);
   endtask

   // Address and data together, response one cycle later, b_ready held high.
   task automatic write_word(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [RW-1:0] exp_resp);
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = a;
      bus.w_valid  = 1'b1; bus.w_data  = d;
      bus.b_ready  = 1'b1;
      check({tag, "_wr_rdy"}, 64'({bus.aw_ready, bus.w_ready}), 64'b11);
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      check({tag, "_b_valid"}, 64'(bus.b_valid), 64'd1);
      check({tag, "_b_resp"},  64'(bus.b_resp),  64'(exp_resp));
      @(posedge clk);
      @(negedge clk);
      bus.b_ready = 1'b0;
      check({tag, "_b_done"}, 64'(bus.b_valid), 64'd0);
   endtask

   task automatic read_word(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp_data, input logic [RW-1:0] exp_resp);
      @(negedge clk);
      bus.ar_valid = 1'b1; bus.ar_addr = a; bus.r_ready = 1'b1;
      check({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.ar_valid = 1'b0;
      check({tag, "_r_valid"}, 64'(bus.r_valid), 64'd1);
      check({tag, "_r_data"},  64'(bus.r_data),  64'(exp_data));
      check({tag, "_r_resp"},  64'(bus.r_resp),  64'(exp_resp));
      @(posedge clk);
      @(negedge clk);
      bus.r_ready = 1'b0;
      check({tag, "_r_done"}, 64'(bus.r_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      arr_size = 5'd16;
      bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.r_ready = 1'b0;
      bus.aw_valid = 1'b0; bus.aw_addr = '0;
      bus.w_valid  = 1'b0; bus.w_data  = '0; bus.b_ready = 1'b0;

      // Reset state
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      read_word("rst_mem0", 4'd0, 32'h0, 1'b0);

      // Preload and read a negative word
      write_word("wr3", 4'd3, 32'hFFFF_FFF6, 1'b0);
      read_word("rd3", 4'd3, 32'hFFFF_FFF6, 1'b0);

      // Data two cycles ahead of the address
      @(negedge clk);
      bus.w_valid = 1'b1; bus.w_data = 32'h12; bus.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.w_valid = 1'b0;
      check("d_first_w_ready",  64'(bus.w_ready),  64'd0);
      check("d_first_aw_ready", 64'(bus.aw_ready), 64'd1);
      check("d_first_b_early",  64'(bus.b_valid),  64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = 4'd5;
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b0;
      check("d_first_b_valid", 64'(bus.b_valid), 64'd1);
      check("d_first_b_resp",  64'(bus.b_resp),  64'd0);
      check("d_first_no_aw",   64'({bus.aw_ready, bus.w_ready}), 64'b00);
      @(posedge clk);
      @(negedge clk);
      bus.b_ready = 1'b0;
      read_word("rd5", 4'd5, 32'h12, 1'b0);

      // Address one cycle ahead of the data
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = 4'd2; bus.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b0;
      check("a_first_aw_ready", 64'(bus.aw_ready), 64'd0);
      check("a_first_w_ready",  64'(bus.w_ready),  64'd1);
      bus.w_valid = 1'b1; bus.w_data = 32'h55;
      @(posedge clk);
      @(negedge clk);
      bus.w_valid = 1'b0;
      check("a_first_b_valid", 64'(bus.b_valid), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.b_ready = 1'b0;
      read_word("rd2", 4'd2, 32'h55, 1'b0);

      // Read held by r_ready low for 4 cycles, then a back-to-back request
      @(negedge clk);
      bus.ar_valid = 1'b1; bus.ar_addr = 4'd3; bus.r_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.ar_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("hold%0d_r_valid", i),  64'(bus.r_valid),  64'd1);
         check($sformatf("hold%0d_r_data", i),   64'(bus.r_data),   64'hFFFF_FFF6);
         check($sformatf("hold%0d_ar_ready", i), 64'(bus.ar_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      bus.r_ready = 1'b1;
      bus.ar_valid = 1'b1; bus.ar_addr = 4'd5;
      @(posedge clk);
      @(negedge clk);
      check("b2b_gap_r_valid",  64'(bus.r_valid),  64'd0);
      check("b2b_gap_ar_ready", 64'(bus.ar_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.ar_valid = 1'b0;
      check("b2b_r_valid", 64'(bus.r_valid), 64'd1);
      check("b2b_r_data",  64'(bus.r_data),  64'h12);
      @(posedge clk);
      @(negedge clk);
      bus.r_ready = 1'b0;
      check("b2b_done", 64'(bus.r_valid), 64'd0);

      // Read and write of the same word on the same edge
      write_word("wr7a", 4'd7, 32'hA, 1'b0);
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = 4'd7; bus.w_valid = 1'b1; bus.w_data = 32'hB;
      bus.ar_valid = 1'b1; bus.ar_addr = 4'd7;
      bus.r_ready  = 1'b1; bus.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
      check("rw_same_r_data",  64'(bus.r_data),  64'hA);
      check("rw_same_b_valid", 64'(bus.b_valid), 64'd1);
      check("rw_same_r_valid", 64'(bus.r_valid), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.r_ready = 1'b0; bus.b_ready = 1'b0;
      read_word("rd7b", 4'd7, 32'hB, 1'b0);

`ifdef SORT_MEM_RANGE_CHECK_EN
      // Bounds checking against arr_size
      arr_size = 5'd6;
      read_word("oob_rd9", 4'd9, 32'h0, 1'b1);
      write_word("oob_wr6", 4'd6, 32'h77, 1'b1);
      read_word("oob_rd6", 4'd6, 32'h0, 1'b1);
      read_word("inb_rd5", 4'd5, 32'h12, 1'b0);
      arr_size = 5'd16;
      read_word("oob_mem6", 4'd6, 32'h0, 1'b0);
`else
      // arr_size has no effect without bounds checking
      arr_size = 5'd2;
      write_word("nochk_wr9", 4'd9, 32'h99, 1'b0);
      read_word("nochk_rd9", 4'd9, 32'h99, 1'b0);
      arr_size = 5'd16;
`endif

      // Reset between aw and w: pair abandoned, memory cleared
      write_word("wr4", 4'd4, 32'h44, 1'b0);
      @(negedge clk);
      bus.aw_valid = 1'b1; bus.aw_addr = 4'd4; bus.b_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.aw_valid = 1'b0;
      check("abort_have_a", 64'({bus.aw_ready, bus.w_ready}), 64'b01);
      bus.w_valid = 1'b1; bus.w_data = 32'hCC;
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      bus.w_valid = 1'b0; bus.b_ready = 1'b0;
      rst_n = 1'b1;
      check("post_rst_b_valid", 64'(bus.b_valid), 64'd0);
      read_word("post_rst_rd4", 4'd4, 32'h0, 1'b0);
      read_word("post_rst_rd3", 4'd3, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_sort_mem_responder

// File: doc/sort_mem_responder.md
SORT_MEM_RESPONDER -- requirements
Module: sort_mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_WDTH, default 4, word-address width; DATA_WDTH, default 32, data width; RESP_WDTH, default 1, response width.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 arr_size  input  ADDR_WDTH+1  number of valid words, 0..2^ADDR_WDTH.
REQ-005 ar_valid, ar_ready  input, output  1 each  read-address handshake.
REQ-006 ar_addr  input  ADDR_WDTH  read word address.
REQ-007 r_valid, r_ready  output, input  1 each  read-data handshake.
REQ-008 r_data, r_resp  output  DATA_WDTH, RESP_WDTH  read word and read status.
REQ-009 aw_valid, aw_ready, aw_addr  input, output, input  1, 1, ADDR_WDTH  write-address channel.
REQ-010 w_valid, w_ready, w_data  input, output, input  1, 1, DATA_WDTH  write-data channel.
REQ-011 b_valid, b_ready, b_resp  output, input, output  1, 1, RESP_WDTH  write-response channel.

Function
REQ-012 Storage SHALL be 2^ADDR_WDTH signed words of DATA_WDTH bits.
REQ-013 A transfer SHALL occur on any rising edge where valid and ready are both 1; valid SHALL hold its payload until that transfer.
REQ-014 Read FSM SHALL have two states: R_IDLE (ar_ready=1, r_valid=0) and R_DATA (ar_ready=0, r_valid=1).
REQ-015 In R_IDLE, an ar transfer SHALL capture mem[ar_addr] into r_data and move to R_DATA, so r_valid rises exactly one cycle after the handshake.
REQ-016 In R_DATA, r_data and r_resp SHALL be stable; an r transfer SHALL return to R_IDLE, and no back-to-back read SHALL be accepted in that same cycle.
REQ-017 Write FSM SHALL have states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP; aw_ready=1 only in W_IDLE/W_HAVE_D, w_ready=1 only in W_IDLE/W_HAVE_A, b_valid=1 only in W_RESP.
REQ-018 aw and w SHALL be accepted in either order or in the same cycle; the memory write SHALL occur on the edge completing the pair, entering W_RESP with b_valid high the next cycle.
REQ-019 A b transfer SHALL return to W_IDLE; no new aw or w SHALL be accepted while in W_RESP.
REQ-020 A read captured on the same edge as a write to the same address SHALL return the pre-write data.
REQ-021 Read and write FSMs SHALL operate independently and concurrently.
REQ-022 r_resp and b_resp SHALL be 0 (OKAY) unless REQ-027 applies.

Reset
REQ-023 While rst_n=0: FSMs in R_IDLE/W_IDLE; ar_ready=1, aw_ready=1, w_ready=1, r_valid=0, b_valid=0, r_data=0, r_resp=0, b_resp=0.
REQ-024 Reset SHALL clear all memory words to 0.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer; a write pair not yet completed SHALL NOT modify memory.

Configuration
REQ-026 Macro SORT_MEM_RANGE_CHECK_EN SHALL select bounds checking.
REQ-027 With SORT_MEM_RANGE_CHECK_EN defined: address >= arr_size SHALL return r_resp=1 with r_data=0, and a write to it SHALL be dropped with b_resp=1; handshake timing unchanged.
REQ-028 Without it: every address SHALL be served normally, responses always 0, arr_size unused.

Structure
REQ-029 Shared package sort_pkg SHALL hold ADDR_WDTH/DATA_WDTH/RESP_WDTH defaults, RESP_OKAY=0, RESP_ERR=1, and the read/write FSM state encodings.
REQ-030 Storage SHALL be one sub-module, sort_mem_array: one synchronous read port, one write port, async clear.

Verification
REQ-031 Preload mem[3]=0xFFFF_FFF6 by write, ar_addr=3 with r_ready=1 -> r_valid one cycle after handshake, r_data=0xFFFF_FFF6, r_resp=0.
REQ-032 w_data=0x12 two cycles before aw_addr=5 -> b_valid one cycle after aw transfer, b_resp=0; read addr 5 -> 0x12.
REQ-033 Hold r_ready=0 for 4 cycles -> r_valid, r_data stable, ar_ready=0 throughout; reads complete on r_ready=1.
REQ-034 mem[7]=0xA, same edge: write 0xB to 7 and read 7 -> r_data=0xA; subsequent read -> 0xB.
REQ-035 SORT_MEM_RANGE_CHECK_EN, arr_size=6: read addr 9 -> r_resp=1, r_data=0; write addr 6 -> b_resp=1, mem[6] unchanged.
REQ-036 Assert rst_n=0 after aw accepted, before w -> all outputs at REQ-023 values, target word reads 0 after reset.
